// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and types for the data-memory responder.
//               The package holds the memory-mapped I/O addresses and the
//               UART transmitter state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Address map. Bits [1:0] of the byte address are ignored by the decode.
    localparam logic [31:0] DMEM_BASE      = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR       = 32'h1000_0000;
    localparam logic [31:0] SW_ADDR        = 32'h1000_0004;
    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0008;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_000C;
    localparam logic [31:0] CYCLES_ADDR    = 32'h1000_0010;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 serial transmitter, LSB first, with a registered line
//               output. A start pulse is accepted only in IDLE; starts that
//               arrive while a frame is in flight are ignored.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset (aborts a frame)
//               start  - request to send data
//               data   - byte to send, captured on an accepted start
//               busy   - high whenever the FSM is not IDLE
//               tx     - serial line, idle high
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import dmem_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int              c_CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(BAUD_DIV - 1);

    uart_state_t     r_state;
    logic [c_CW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;

    // The line level for the next state is registered together with the
    // state, so tx changes on the same edge that enters each bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (start) begin
                        r_state <= START;
                        r_baud  <= c_BAUD_LAST;
                        r_shift <= data;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (r_baud == '0) begin
                        r_state <= DATA;
                        r_bit   <= 3'd0;
                        r_baud  <= c_BAUD_LAST;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= c_BAUD_LAST;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                STOP: begin
                    if (r_baud == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Writeback-stage data-memory responder. Word RAM plus an I/O
//               page (LEDs, switches, cycle counter, UART). Loads return one
//               cycle after the address; stores commit at the end of the
//               MemWE cycle; RAM reads are read-first.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               MemWE, Addr, WD- store strobe, byte address, store data
//               ReadData       - registered load data
//               sw / led       - board switches (async) / board LEDs
//               uart_tx        - serial output, idle high
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWE,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] ReadData,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        uart_tx
);

    localparam int c_BAUD_DIV = CLK_HZ / BAUD;
    localparam int c_AW       = $clog2(DMEM_WORDS);

    logic [31:0]     w_word;
    logic            w_is_ram;
    logic [c_AW-1:0] w_idx;
    logic            w_store;
    logic            w_uart_busy;
    logic [31:0]     w_io_rd;
    logic            w_unused;

    logic [31:0] r_mem [DMEM_WORDS];
    logic [31:0] r_ram_rd;
    logic [31:0] r_io_rd;
    logic        r_rd_ram;
    logic [15:0] r_led;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [31:0] r_cycles;

    assign w_word   = {Addr[31:2], 2'b00};
    assign w_is_ram = (Addr[31:12] == DMEM_BASE[31:12]);
    // Higher index bits are dropped, so out-of-range indices alias.
    assign w_idx    = Addr[c_AW+1:2];
    assign w_store  = MemWE & ~reset;
    assign w_unused = &{1'b0, Addr[1:0]};

    // RAM kept free of reset and of the I/O mux so it maps onto block RAM;
    // the read port samples the old word when the same index is written.
    always_ff @(posedge clk) begin
        if (w_store && w_is_ram) begin
            r_mem[w_idx] <= WD;
        end
        r_ram_rd <= r_mem[w_idx];
    end

    always_comb begin
        w_io_rd = '0;
        case (w_word)
            LED_ADDR:       w_io_rd = {16'b0, r_led};
            SW_ADDR:        w_io_rd = {16'b0, r_sw_sync};
            UART_STAT_ADDR: w_io_rd = {31'b0, w_uart_busy};
            CYCLES_ADDR:    w_io_rd = r_cycles;
            default:        w_io_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_cycles  <= '0;
            r_io_rd   <= '0;
            r_rd_ram  <= 1'b0;
        end else begin
            if (MemWE && (w_word == LED_ADDR)) begin
                r_led <= WD[15:0];
            end
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            r_cycles  <= r_cycles + 32'd1;
            r_io_rd   <= w_io_rd;
            r_rd_ram  <= w_is_ram;
        end
    end

    // Final select after the registers: a clear r_rd_ram yields the reset 0.
    assign ReadData = r_rd_ram ? r_ram_rd : r_io_rd;
    assign led      = r_led;

    uart_tx #(
        .BAUD_DIV (c_BAUD_DIV)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (w_store && (w_word == UART_DATA_ADDR)),
        .data  (WD[7:0]),
        .busy  (w_uart_busy),
        .tx    (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder with a
//               4-cycle UART bit period and a 256-word RAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        MemWE;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] ReadData;
    logic [15:0] sw;
    logic [15:0] led;
    logic        uart_tx;

    int n_total;
    int n_bad;

    dmem_responder #(
        .DMEM_WORDS (256),
        .CLK_HZ     (40),
        .BAUD       (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWE    (MemWE),
        .Addr     (Addr),
        .WD       (WD),
        .ReadData (ReadData),
        .sw       (sw),
        .led      (led),
        .uart_tx  (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWE = 1'b1;
        Addr  = a;
        WD    = d;
        step();
        MemWE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       eb;
        int         j;

        n_total = 0;
        n_bad   = 0;
        reset = 1'b1; MemWE = 1'b0; Addr = '0; WD = '0; sw = '0;
        step();
        step();
        check("rst_rd",  ReadData, 32'h0);
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_tx",  {31'b0, uart_tx}, 32'h1);
        reset = 1'b0;

        // RAM round trip
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h0);
        Addr = 32'h0000_0010; step();
        check("ram_rd10", ReadData, 32'hDEAD_BEEF);
        Addr = 32'h0000_0014; step();
        check("ram_rd14", ReadData, 32'h0);

        // Read-first on a same-cycle store
        wr(32'h0000_0020, 32'hAAAA_AAAA);
        MemWE = 1'b1; Addr = 32'h0000_0020; WD = 32'h1234_5678;
        step();
        MemWE = 1'b0;
        check("ram_rdfirst", ReadData, 32'hAAAA_AAAA);
        step();
        check("ram_rdnew", ReadData, 32'h1234_5678);

        // Index 256 aliases onto index 0 in a 256-word RAM
        wr(32'h0000_0400, 32'h0BAD_F00D);
        Addr = 32'h0000_0000; step();
        check("ram_alias", ReadData, 32'h0BAD_F00D);

        // Unmapped store must not touch RAM; unmapped load returns 0
        wr(32'h2000_0010, 32'hFFFF_FFFF);
        Addr = 32'h0000_0010; step();
        check("ram_keep", ReadData, 32'hDEAD_BEEF);
        Addr = 32'h2000_0000; step();
        check("unmapped", ReadData, 32'h0);

        // LEDs
        wr(32'h1000_0000, 32'hFFFF_00A5);
        check("led_out", {16'b0, led}, 32'h0000_00A5);
        Addr = 32'h1000_0000; step();
        check("led_rd", ReadData, 32'h0000_00A5);

        // UART frame of 0x55, second write at cycle 10 dropped
        d = 8'h55;
        wr(32'h1000_0008, {24'h0, d});
        Addr = 32'h1000_000C;
        for (int k = 0; k < 40; k++) begin
            j = k / 4;
            if (j == 0)      eb = 1'b0;
            else if (j == 9) eb = 1'b1;
            else             eb = d[j-1];
            check($sformatf("tx_k%0d", k), {31'b0, uart_tx}, {31'b0, eb});
            if (k >= 1 && k != 11) begin
                check($sformatf("busy_k%0d", k), ReadData, 32'h1);
            end
            if (k == 10) begin
                MemWE = 1'b1; Addr = 32'h1000_0008; WD = 32'h0000_00FF;
            end else begin
                MemWE = 1'b0; Addr = 32'h1000_000C;
            end
            step();
        end
        check("tx_idle", {31'b0, uart_tx}, 32'h1);
        step();
        check("busy_end", ReadData, 32'h0);
        check("tx_idle2", {31'b0, uart_tx}, 32'h1);

        // Reset mid-frame, with a simultaneous LED store that must lose
        wr(32'h1000_0008, 32'h0000_0000);
        Addr = 32'h1000_000C;
        repeat (14) step();
        check("tx_mid", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1; MemWE = 1'b1; Addr = 32'h1000_0000; WD = 32'h0000_1234;
        step();
        reset = 1'b0; MemWE = 1'b0;
        check("abort_tx",  {31'b0, uart_tx}, 32'h1);
        check("abort_led", {16'b0, led}, 32'h0);
        check("abort_rd",  ReadData, 32'h0);
        Addr = 32'h1000_0010; step();
        check("cyc0", ReadData, 32'h0);
        step();
        check("cyc1", ReadData, 32'h1);
        Addr = 32'h1000_000C; step();
        check("abort_stat", ReadData, 32'h0);
        check("abort_tx2", {31'b0, uart_tx}, 32'h1);

        // Counter wrap
        Addr = 32'h1000_0010;
        force dut.r_cycles = 32'hFFFF_FFFF;
        step();
        check("cyc_max", ReadData, 32'hFFFF_FFFF);
        release dut.r_cycles;
        step();
        check("cyc_max2", ReadData, 32'hFFFF_FFFF);
        step();
        check("cyc_wrap", ReadData, 32'h0);

        // Switch synchroniser: two cycles of old value, then new
        Addr = 32'h1000_0004;
        sw = 16'h8001;
        step();
        check("sw_old1", ReadData, 32'h0);
        step();
        check("sw_old2", ReadData, 32'h0);
        step();
        check("sw_new", ReadData, 32'h0000_8001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's Writeback-stage load/store port: it answers the `ALUResultW` address, `WD` write data and write-enable with `ReadData` one cycle later. It holds a block-RAM word array plus a memory-mapped I/O page (Basys 3 LEDs, switches, free-running cycle counter and a UART transmitter), all in one clock domain. The registered, one-cycle read latency is the timing the core's load stall buffer is built around.

## Interface
Parameters:
- `DMEM_WORDS`, 1024: RAM depth in 32-bit words; power of two, up to 1024.
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: UART bit rate; `BAUD_DIV = CLK_HZ/BAUD` (868 at the defaults).

Ports:
- `clk`  in  1  system clock. One clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MemWE`  in  1  store strobe from control, Writeback stage.
- `Addr`  in  32  byte address (`ALUResultW`).
- `WD`  in  32  store data.
- `ReadData`  out  32  registered load data.
- `sw`  in  16  board switches (asynchronous).
- `led`  out  16  board LEDs.
- `uart_tx`  out  1  serial line, idle high.

## Operation
Address map; `Addr[1:0]` is ignored and all accesses are full-word:
- `0x0000_0000`–`0x0000_0FFF` RAM:
  - Word index is `Addr[11:2]`, masked to `$clog2(DMEM_WORDS)` bits.
  - Accesses with index ≥ `DMEM_WORDS` alias onto the masked index.
  - Contents are not reset.
- `0x1000_0000` LED: read/write; write loads `WD[15:0]`; read returns `{16'b0, led}`.
- `0x1000_0004` SW: read-only; returns `{16'b0, sw_sync}`. `sw_sync` comes from a two-flop synchroniser.
- `0x1000_0008` UART_DATA:
  - Write while idle: latches `WD[7:0]` and starts a frame.
  - Write while busy: dropped silently.
  - Read returns 0.
- `0x1000_000C` UART_STAT: read-only; bit 0 = `busy`, other bits 0.
- `0x1000_0010` CYCLES: read-only; free-running 32-bit up-counter that wraps `0xFFFF_FFFF` → 0.
- Any other address: reads return 0, writes are ignored.
- Read-only registers ignore writes.

Read rules:
- `ReadData` is updated every cycle from the current `Addr`, whether or not `MemWE` is set. There is no read strobe.
- A RAM read of the same address that is being written in that cycle returns the old word (read-first).

UART transmitter, 8N1, LSB first. FSM:
- IDLE: line = 1. On an accepted UART_DATA write → START, baud counter = `BAUD_DIV-1`.
- START: line = 0 for `BAUD_DIV` cycles, then → DATA with bit index 0.
- DATA: line = `shift[bit]` for `BAUD_DIV` cycles per bit. After bit 7 → STOP.
- STOP: line = 1 for `BAUD_DIV` cycles, then → IDLE.
- `busy = (state != IDLE)`.
- The baud counter counts down from `BAUD_DIV-1` to 0; the state or bit advances at 0.

## Timing
- Load latency: `Addr` presented in cycle N → `ReadData` valid in cycle N+1 and held until the N+1 edge reloads it.
- Store commit: RAM, LED or UART state changes at the edge that ends the `MemWE` cycle.
  - A read of the same location in N+1 returns the new value.
- `led`: changes on the edge after the store.
- CYCLES read: returns the counter value sampled at the edge ending cycle N.
- UART start: `uart_tx` falls in the cycle after the accepted write. `busy` reads 1 from that cycle on.
- Frame length: exactly `10*BAUD_DIV` cycles, after which `busy` = 0.
- Back-to-back sends: a write accepted in the first IDLE cycle after STOP starts the next frame with no gap.
- `sw` → `sw_sync`: 2 cycles of latency.
- Reset values, asserted on the next edge:
  - `ReadData` = 0, `led` = 0, `uart_tx` = 1.
  - Cycle counter = 0, synchroniser = 0.
  - UART state = IDLE, baud counter = 0, shift register = 0.
- Reset mid-frame aborts the frame: line goes high on the next edge with no partial stop bit.
- Reset has priority over a simultaneous store.

## Structure
- Package `dmem_pkg`:
  - Address constants `DMEM_BASE`, `LED_ADDR`, `SW_ADDR`, `UART_DATA_ADDR`, `UART_STAT_ADDR`, `CYCLES_ADDR`.
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`.
- Sub-module `uart_tx`:
  - Parameter `BAUD_DIV`.
  - Ports `clk`, `reset`, `start`, `data[7:0]`, `busy`, `tx`.
- Top level: address decode, RAM array (inferable as block RAM), LED register, synchroniser, counter and read mux.

## Test plan
- RAM round-trip: store `0xDEADBEEF` at `0x0000_0010`, then load `0x10` → `ReadData = 0xDEADBEEF` one cycle after the load address.
  - Load `0x0000_0014` → 0 (after an initialising write of 0).
- Read-first and LEDs:
  - Same-cycle store `0x1234_5678` and load of a word holding `0xAAAA_AAAA` → `0xAAAA_AAAA`; the next-cycle read → `0x1234_5678`.
  - Store `0xFFFF_00A5` to `0x1000_0000` → `led = 0x00A5`, readback `0x0000_00A5`.
- UART frame: `BAUD_DIV = 4`, store `0x55` to UART_DATA → `uart_tx` bit sequence `0,1,0,1,0,1,0,1,0,1`, each bit 4 cycles. STAT bit 0 is 1 throughout and 0 after 40 cycles.
  - A second write at cycle 10 is dropped.
- Reset mid-frame, with unmapped read and counter wrap:
  - Assert `reset` at cycle 15 of a frame → `uart_tx = 1`, STAT = 0, `led = 0`, `ReadData = 0` after the edge.
  - Read `0x2000_0000` → 0.
  - Force the counter to `0xFFFF_FFFF` → the next read returns 0.
- Switch synchroniser: change `sw` to `0x8001` → SW reads return the old value for 2 cycles, then `0x0000_8001`.
